mul_share_arbiter: RTL

Shares one pipelined integer multiplier unit between `NR_REQ` independent requesters (e.g. two issue lanes) using round-robin arbitration. It tracks every in-flight operation's source, routes each result back to a per-requester result FIFO, and uses credit-based issue so that a multiplier result is never dropped. The multiplier itself has no backpressure. The block sits between the issue stage and the multiplier inside the functional-unit cluster, and supports a pipeline flush.

---
 rtl/mul_share_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one pipelined, non-stallable integer multiplier between NR_REQ
//   requesters. A combinational round-robin arbiter picks one eligible
//   requester per cycle. A tag pipe remembers which requester issued each
//   in-flight op, so that the returning result goes to that requester's
//   first-word-fall-through result FIFO. Issue is credit-based, so a result
//   always finds a free slot.
//
// Operation encoding (fu_op, 3 bits):
//   MUL=0, MULH=1, MULHU=2, MULHSU=3, MULW=4
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop every in-flight and buffered op
//   req_valid_i/ready_o   per-requester handshake (ready is one-hot or zero)
//   req_op_i/a_i/b_i      per-requester operation and operands
//   req_trans_id_i        per-requester transaction ID
//   mul_*_o               issue port to the multiplier
//   mul_valid_i/result_i  multiplier result, MUL_LATENCY cycles after issue
//   mul_trans_id_i        transaction ID returned with the result
//   res_valid_o/ready_i   per-requester result FIFO head handshake
//   res_data_o/trans_id_o per-requester FIFO head contents (zero when empty)
module mul_share_arbiter #(
  parameter int NR_REQ        = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 2,
  parameter int MUL_LATENCY   = 1,
  parameter int RES_DEPTH     = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic [NR_REQ-1:0]                      req_valid_i,
  output logic [NR_REQ-1:0]                      req_ready_o,
  input  logic [NR_REQ-1:0][2:0]                 req_op_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]            req_a_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]            req_b_i,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]   req_trans_id_i,
  output logic                                   mul_valid_o,
  output logic [2:0]                             mul_op_o,
  output logic [XLEN-1:0]                        mul_a_o,
  output logic [XLEN-1:0]                        mul_b_o,
  output logic [TRANS_ID_BITS-1:0]               mul_trans_id_o,
  input  logic                                   mul_valid_i,
  input  logic [XLEN-1:0]                        mul_result_i,
  input  logic [TRANS_ID_BITS-1:0]               mul_trans_id_i,
  output logic [NR_REQ-1:0]                      res_valid_o,
  input  logic [NR_REQ-1:0]                      res_ready_i,
  output logic [NR_REQ-1:0][XLEN-1:0]            res_data_o,
  output logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]   res_trans_id_o
);

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam int RR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RES_DEPTH);

  // Control state
  logic [RR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       credit_q [NR_REQ];
  logic [CNT_W-1:0]       credit_d [NR_REQ];
  logic [MUL_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]       wr_ptr_q [NR_REQ];
  logic [PTR_W-1:0]       wr_ptr_d [NR_REQ];
  logic [PTR_W-1:0]       rd_ptr_q [NR_REQ];
  logic [PTR_W-1:0]       rd_ptr_d [NR_REQ];
  logic [CNT_W-1:0]       cnt_q    [NR_REQ];
  logic [CNT_W-1:0]       cnt_d    [NR_REQ];

  // Data state (not reset: only meaningful under a valid/count)
  logic [RR_W-1:0]          tag_src_q  [MUL_LATENCY];
  logic [RR_W-1:0]          tag_src_d  [MUL_LATENCY];
  logic [XLEN-1:0]          mem_data_q [NR_REQ][RES_DEPTH];
  logic [XLEN-1:0]          mem_data_d [NR_REQ][RES_DEPTH];
  logic [TRANS_ID_BITS-1:0] mem_id_q   [NR_REQ][RES_DEPTH];
  logic [TRANS_ID_BITS-1:0] mem_id_d   [NR_REQ][RES_DEPTH];

  logic [NR_REQ-1:0] eligible, grant, push, pop;
  logic              grant_any;
  logic [RR_W-1:0]   grant_idx;
  logic [RR_W:0]     arb_sum;
  logic [RR_W-1:0]   arb_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stage: arbitration (combinational). Credits come only from registered
  // state, so res_ready_i has no combinational path to req_ready_o.
  always_comb begin
    eligible  = '0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (credit_q[i] != '0);
    end
    for (int k = 0; k < NR_REQ; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(k);
      if (arb_sum >= (RR_W+1)'(NR_REQ)) arb_sum = arb_sum - (RR_W+1)'(NR_REQ);
      arb_idx = arb_sum[RR_W-1:0];
      if (!grant_any && !flush_i && !rst_i && eligible[arb_idx]) begin
        grant[arb_idx] = 1'b1;
        grant_any      = 1'b1;
        grant_idx      = arb_idx;
      end
    end
  end

  assign req_ready_o = grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == RR_W'(NR_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
    end
  end

  // Issue mux: zero operands and MUL when idle.
  always_comb begin
    mul_valid_o    = grant_any;
    mul_op_o       = OP_MUL;
    mul_a_o        = '0;
    mul_b_o        = '0;
    mul_trans_id_o = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant[i]) begin
        mul_op_o       = req_op_i[i];
        mul_a_o        = req_a_i[i];
        mul_b_o        = req_b_i[i];
        mul_trans_id_o = req_trans_id_i[i];
      end
    end
  end

  // Stage: tag pipe, last stage lines up with mul_valid_i.
  always_comb begin
    tag_vld_d    = '0;
    tag_src_d    = tag_src_q;
    tag_vld_d[0] = grant_any;
    tag_src_d[0] = grant_idx;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_src_d[k] = tag_src_q[k-1];
    end
    if (flush_i) tag_vld_d = '0;
  end

  // Stage: result FIFOs and credits.
  always_comb begin
    for (int i = 0; i < NR_REQ; i++) begin
      res_valid_o[i] = (cnt_q[i] != '0);
      push[i] = tag_vld_q[MUL_LATENCY-1] && (tag_src_q[MUL_LATENCY-1] == RR_W'(i)) && !flush_i;
      pop[i]  = res_valid_o[i] && res_ready_i[i] && !flush_i;
    end
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_id_d   = mem_id_q;
    for (int i = 0; i < NR_REQ; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      credit_d[i] = credit_q[i];
      if (push[i]) begin
        mem_data_d[i][wr_ptr_q[i]] = mul_result_i;
        mem_id_d[i][wr_ptr_q[i]]   = mul_trans_id_i;
        wr_ptr_d[i]                = ptr_inc(wr_ptr_q[i]);
      end
      if (pop[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - CNT_W'(1);
        2'b01:   credit_d[i] = credit_q[i] + CNT_W'(1);
        default: credit_d[i] = credit_q[i];
      endcase
      if (flush_i) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
        credit_d[i] = CREDIT_MAX;
      end
    end
  end

  // Head outputs are forced to zero when empty so reset leaves them clean.
  always_comb begin
    for (int i = 0; i < NR_REQ; i++) begin
      res_data_o[i]     = res_valid_o[i] ? mem_data_q[i][rd_ptr_q[i]] : '0;
      res_trans_id_o[i] = res_valid_o[i] ? mem_id_q[i][rd_ptr_q[i]]   : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < NR_REQ; i++) begin
        credit_q[i] <= CREDIT_MAX;
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < NR_REQ; i++) begin
        credit_q[i] <= credit_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    tag_src_q  <= tag_src_d;
    mem_data_q <= mem_data_d;
    mem_id_q   <= mem_id_d;
  end

  // A tracked op must come back exactly when the tag pipe says so.
  a_tag_align: assert property (@(posedge clk_i) disable iff (rst_i)
    tag_vld_q[MUL_LATENCY-1] |-> mul_valid_i);

  for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_fifo_chk
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (push[gi] && (cnt_q[gi] == CREDIT_MAX)) |-> pop[gi]);
  end

endmodule
